// File: rtl/bus_generator_arbiter.sv
// Per-bus round-robin arbiter: pops one pending device FIFO head and pushes the packet to its destination(s).
// Optional feature macro BUS_BROADCAST_EN: when defined, the broadcast ID reaches every device except the source.
module bus_generator_arbiter #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [bits-1:0][drvrs-1:0]                  pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]     D_pop,
  output logic [bits-1:0][drvrs-1:0]                  pop,
  output logic [bits-1:0][drvrs-1:0]                  push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]     D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

`ifdef BUS_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    POP,
    PUSH
  } state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t              state_q, state_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       last_q, last_d;
    logic [drvrs-1:0]    pop_q, pop_d;
    logic [drvrs-1:0]    push_q, push_d;
    logic [pckg_sz-1:0]  d_push_q, d_push_d;
    logic [pckg_sz-1:0]  head;
    logic [7:0]          dest;
    logic                is_bcast;
    int                  idx;

    assign head     = D_pop[b][grant_q];
    assign dest     = head[pckg_sz-1 -: 8];
    assign is_bcast = (dest == broadcast);

    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      pop_d    = '0;
      push_d   = '0;
      d_push_d = d_push_q;
      idx      = 0;
      unique case (state_q)
        IDLE: begin
          if (|pndng[b]) begin
            // Scan downward in offset so the smallest offset after last_q is the last writer.
            for (int k = drvrs; k >= 1; k--) begin
              idx = (int'(last_q) + k) % drvrs;
              if (pndng[b][idx]) grant_d = IW'(idx);
            end
            for (int d = 0; d < drvrs; d++) pop_d[d] = (int'(grant_d) == d);
            state_d = POP;
          end
        end
        POP: begin
          last_d   = grant_q;
          d_push_d = head;
          for (int d = 0; d < drvrs; d++) begin
            if (int'(dest) < drvrs)          push_d[d] = (int'(dest) == d);
            else if (BCAST_EN && is_bcast)   push_d[d] = (int'(grant_q) != d);
          end
          state_d = PUSH;
        end
        PUSH:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= IDLE;
        grant_q  <= IW'(drvrs - 1);
        last_q   <= IW'(drvrs - 1);
        pop_q    <= '0;
        push_q   <= '0;
        d_push_q <= '0;
      end else begin
        state_q  <= state_d;
        grant_q  <= grant_d;
        last_q   <= last_d;
        pop_q    <= pop_d;
        push_q   <= push_d;
        d_push_q <= d_push_d;
      end
    end

    assign pop[b]    = pop_q;
    assign push[b]   = push_q;
    assign D_push[b] = {drvrs{d_push_q}};
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Self-checking bench for bus_generator_arbiter: directed vector table, fairness sequence, random run vs model.
module tb_bus_generator_arbiter;
  localparam int BITS  = 2;
  localparam int DRVRS = 4;
  localparam int PSZ   = 16;

`ifdef BUS_BROADCAST_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [BITS-1:0][DRVRS-1:0]          pndng, pop, push;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] d_pop, d_push;

  int vectors     = 0;
  int miscompares = 0;

  bus_generator_arbiter #(
    .bits(BITS), .drvrs(DRVRS), .pckg_sz(PSZ), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  pnd;
    logic [15:0] data;
    logic [3:0]  e_pop;
    logic [3:0]  e_push;
    logic [15:0] e_dp;
  } vec_t;

  vec_t tbl[16];

  // Transaction-level reference: one record per bus of where it is in its 3-cycle transfer.
  int          step[BITS];
  int          gr[BITS];
  int          last[BITS];
  int          refresh[BITS];
  logic [15:0] pkt[BITS];
  logic [BITS-1:0][DRVRS-1:0]          exp_pop, exp_push;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] exp_dp;

  function automatic logic [3:0] dest_mask(input logic [15:0] p, input int src);
    int dst;
    dst = int'(p[15:8]);
    if (dst < DRVRS) return 4'(1 << dst);
    if (BC_EN && dst == 255) return 4'hF & ~4'(1 << src);
    return 4'h0;
  endfunction

  function automatic logic [15:0] rand_pkt();
    int sel;
    logic [7:0] dst;
    sel = int'($urandom_range(0, 7));
    if (sel < 4)       dst = 8'(sel);
    else if (sel < 6)  dst = 8'hFF;
    else if (sel == 6) dst = 8'($urandom_range(4, 254));
    else               dst = 8'($urandom_range(0, 3));
    return {dst, 8'($urandom)};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BITS; b++) begin
      step[b] = 0; gr[b] = 0; last[b] = DRVRS - 1; refresh[b] = -1; pkt[b] = '0;
    end
    exp_pop = '0; exp_push = '0; exp_dp = '0;
  endtask

  task automatic model_edge();
    for (int b = 0; b < BITS; b++) begin
      if (step[b] == 0) begin
        exp_pop[b]  = '0;
        exp_push[b] = '0;
        if (pndng[b] != '0) begin
          for (int k = DRVRS; k >= 1; k--)
            if (pndng[b][(last[b] + k) % DRVRS]) gr[b] = (last[b] + k) % DRVRS;
          exp_pop[b][gr[b]] = 1'b1;
          pkt[b]  = d_pop[b][gr[b]];
          step[b] = 2;
        end
      end else if (step[b] == 2) begin
        exp_pop[b]  = '0;
        last[b]     = gr[b];
        exp_dp[b]   = {DRVRS{pkt[b]}};
        exp_push[b] = dest_mask(pkt[b], gr[b]);
        refresh[b]  = gr[b];
        step[b]     = 1;
      end else begin
        exp_push[b] = '0;
        step[b]     = 0;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 16'h0000, 4'h0, 4'h0, 16'h0000};
    tbl[1]  = '{1'b1, 4'hF, 16'h0000, 4'h0, 4'h0, 16'h0000};
    tbl[2]  = '{1'b0, 4'h2, 16'h02AB, 4'h2, 4'h0, 16'h0000};
    tbl[3]  = '{1'b0, 4'h0, 16'h02AB, 4'h0, 4'h4, 16'h02AB};
    tbl[4]  = '{1'b0, 4'h0, 16'h02AB, 4'h0, 4'h0, 16'h02AB};
    tbl[5]  = '{1'b0, 4'h4, 16'hFF5A, 4'h4, 4'h0, 16'h02AB};
    tbl[6]  = '{1'b0, 4'h0, 16'hFF5A, 4'h0, BC_EN ? 4'hB : 4'h0, 16'hFF5A};
    tbl[7]  = '{1'b0, 4'h0, 16'hFF5A, 4'h0, 4'h0, 16'hFF5A};
    tbl[8]  = '{1'b0, 4'h1, 16'h0711, 4'h1, 4'h0, 16'hFF5A};
    tbl[9]  = '{1'b0, 4'h0, 16'h0711, 4'h0, 4'h0, 16'h0711};
    tbl[10] = '{1'b0, 4'h0, 16'h0711, 4'h0, 4'h0, 16'h0711};
    tbl[11] = '{1'b0, 4'h8, 16'h0300, 4'h8, 4'h0, 16'h0711};
    tbl[12] = '{1'b1, 4'h8, 16'h0300, 4'h0, 4'h0, 16'h0000};
    tbl[13] = '{1'b0, 4'hF, 16'h0000, 4'h1, 4'h0, 16'h0000};
    tbl[14] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h1, 16'h0000};
    tbl[15] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0000};

    reset = 1'b1;
    pndng = '0;
    d_pop = '0;

    // Directed table on bus 0; bus 1 stays idle and must stay quiet.
    for (int i = 0; i < 16; i++) begin
      reset    = tbl[i].rst;
      pndng[0] = tbl[i].pnd;
      pndng[1] = '0;
      for (int d = 0; d < DRVRS; d++) d_pop[0][d] = tbl[i].data;
      @(negedge clk);
      check($sformatf("tbl%0d pop", i),  64'(pop),  64'({4'h0, tbl[i].e_pop}));
      check($sformatf("tbl%0d push", i), 64'(push), 64'({4'h0, tbl[i].e_push}));
      check($sformatf("tbl%0d dpush", i), 64'(d_push[0][0]), 64'(tbl[i].e_dp));
      check($sformatf("tbl%0d dpush3", i), 64'(d_push[0][3]), 64'(tbl[i].e_dp));
      check($sformatf("tbl%0d bus1 dpush", i), 64'(d_push[1]), 64'(0));
    end

    // Fairness: all four pending, dropped destination; grants 0,1,2,3,0 every third cycle.
    reset = 1'b1;
    pndng = '0;
    for (int d = 0; d < DRVRS; d++) d_pop[0][d] = {8'h05, 8'(d)};
    @(negedge clk);
    reset    = 1'b0;
    pndng[0] = 4'hF;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check($sformatf("fair%0d pop", i), 64'(pop[0]),
            (i % 3 == 1) ? 64'(1 << ((i / 3) % 4)) : 64'(0));
      check($sformatf("fair%0d push", i), 64'(push[0]), 64'(0));
    end

    // Random run on both buses against the transaction model.
    reset = 1'b1;
    pndng = '0;
    for (int b = 0; b < BITS; b++)
      for (int d = 0; d < DRVRS; d++) d_pop[b][d] = rand_pkt();
    @(negedge clk);
    model_reset();
    check("rand reset pop", 64'(pop), 64'(0));
    check("rand reset push", 64'(push), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < BITS; b++) begin
        if (refresh[b] >= 0) d_pop[b][refresh[b]] = rand_pkt();
        refresh[b] = -1;
        pndng[b]   = 4'($urandom) & 4'($urandom);
      end
      model_edge();
      @(negedge clk);
      check($sformatf("rand%0d pop", c),  64'(pop),  64'(exp_pop));
      check($sformatf("rand%0d push", c), 64'(push), 64'(exp_push));
      for (int b = 0; b < BITS; b++)
        check($sformatf("rand%0d dpush%0d", c, b), 64'(d_push[b][0]), 64'(exp_dp[b][0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
